// File: rtl/rcu_pll_seq.sv
// rtl/rcu_pll_seq.sv - reference-clock sequencer: PLL config, power-cycle, lock qualify, glitch-free switch-in
// Optional macro RCU_PLL_LOSS_EN: drop back to bypass and re-qualify lock when lock is lost in RUN.
module rcu_pll_seq #(
    parameter int REFDIV_WIDTH  = 6,
    parameter int FBDIV_WIDTH   = 12,
    parameter int POSTDIV_WIDTH = 3,
    parameter int PD_CYCLES     = 16,
    parameter int STABLE_CYCLES = 64,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int SWITCH_CYCLES = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    input  logic                     cfg_byp_i,
    input  logic [REFDIV_WIDTH-1:0]  cfg_refdiv_i,
    input  logic [FBDIV_WIDTH-1:0]   cfg_fbdiv_i,
    input  logic [POSTDIV_WIDTH-1:0] cfg_pdiv1_i,
    input  logic [POSTDIV_WIDTH-1:0] cfg_pdiv2_i,
    input  logic                     pll_lock_i,
    output logic                     pll_pd_o,
    output logic [REFDIV_WIDTH-1:0]  pll_refdiv_o,
    output logic [FBDIV_WIDTH-1:0]   pll_fbdiv_o,
    output logic [POSTDIV_WIDTH-1:0] pll_pdiv1_o,
    output logic [POSTDIV_WIDTH-1:0] pll_pdiv2_o,
    output logic                     pll_sel_o,
    output logic                     busy_o,
    output logic                     locked_o,
    output logic                     err_cfg_o,
    output logic                     err_tmo_o
);
    localparam int HOLD_MAX = (PD_CYCLES > SWITCH_CYCLES) ? PD_CYCLES : SWITCH_CYCLES;
    localparam int CNT_W    = $clog2(HOLD_MAX) + 1;
    localparam int STAB_W   = $clog2(STABLE_CYCLES) + 1;
    localparam int TMO_W    = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  SW_LAST   = CNT_W'(SWITCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  PD_LAST   = CNT_W'(PD_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_DONE = STAB_W'(STABLE_CYCLES);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_SW_OUT, S_PD, S_WAIT_LOCK, S_SW_IN, S_RUN} state_t;

    state_t                   state_q, state_d;
    logic                     lock_meta_q, lock_meta_d, lock_s_q, lock_s_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [STAB_W-1:0]        stab_q, stab_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic                     byp_q, byp_d;
    logic [REFDIV_WIDTH-1:0]  cap_refdiv_q, cap_refdiv_d, refdiv_q, refdiv_d;
    logic [FBDIV_WIDTH-1:0]   cap_fbdiv_q, cap_fbdiv_d, fbdiv_q, fbdiv_d;
    logic [POSTDIV_WIDTH-1:0] cap_pdiv1_q, cap_pdiv1_d, pdiv1_q, pdiv1_d;
    logic [POSTDIV_WIDTH-1:0] cap_pdiv2_q, cap_pdiv2_d, pdiv2_q, pdiv2_d;
    logic                     pd_q, pd_d, sel_q, sel_d, ready_q, ready_d, busy_q, busy_d;
    logic                     locked_q, locked_d, err_cfg_q, err_cfg_d, err_tmo_q, err_tmo_d;
`ifdef RCU_PLL_LOSS_EN
    logic                     lost_q, lost_d;
`endif
    logic                     accept, cfg_bad;
    logic [STAB_W-1:0]        stab_inc;

    assign accept  = cfg_valid_i && ready_q;
    assign cfg_bad = !cfg_byp_i && ((cfg_refdiv_i == '0) || (cfg_fbdiv_i == '0) ||
                                    (cfg_pdiv1_i == '0) || (cfg_pdiv2_i == '0));

    always_comb begin
        state_d      = state_q;
        lock_meta_d  = pll_lock_i;
        lock_s_d     = lock_meta_q;
        cnt_d        = cnt_q;
        stab_d       = stab_q;
        tmo_d        = tmo_q;
        byp_d        = byp_q;
        cap_refdiv_d = cap_refdiv_q;
        cap_fbdiv_d  = cap_fbdiv_q;
        cap_pdiv1_d  = cap_pdiv1_q;
        cap_pdiv2_d  = cap_pdiv2_q;
        refdiv_d     = refdiv_q;
        fbdiv_d      = fbdiv_q;
        pdiv1_d      = pdiv1_q;
        pdiv2_d      = pdiv2_q;
        pd_d         = pd_q;
        sel_d        = sel_q;
        ready_d      = ready_q;
        busy_d       = busy_q;
        locked_d     = locked_q;
        err_cfg_d    = 1'b0;
        err_tmo_d    = err_tmo_q;
        stab_inc     = '0;
`ifdef RCU_PLL_LOSS_EN
        lost_d       = (state_q == S_RUN) && !lock_s_q;
`endif
        case (state_q)
            S_IDLE, S_RUN: begin
                if (accept) begin
                    if (cfg_bad) begin
                        err_cfg_d = 1'b1;
                    end else begin
                        byp_d        = cfg_byp_i;
                        cap_refdiv_d = cfg_refdiv_i;
                        cap_fbdiv_d  = cfg_fbdiv_i;
                        cap_pdiv1_d  = cfg_pdiv1_i;
                        cap_pdiv2_d  = cfg_pdiv2_i;
                        state_d      = S_SW_OUT;
                        cnt_d        = '0;
                        sel_d        = 1'b0;
                        locked_d     = 1'b0;
                        ready_d      = 1'b0;
                        busy_d       = 1'b1;
                        err_tmo_d    = 1'b0;
                    end
                end
`ifdef RCU_PLL_LOSS_EN
                // Two synced-low samples in RUN: fall back to bypass, keep PLL powered.
                else if ((state_q == S_RUN) && !lock_s_q && lost_q) begin
                    state_d   = S_WAIT_LOCK;
                    sel_d     = 1'b0;
                    locked_d  = 1'b0;
                    err_tmo_d = 1'b1;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    stab_d    = '0;
                    tmo_d     = '0;
                end
`endif
            end
            S_SW_OUT: begin
                if (cnt_q == SW_LAST) begin
                    state_d  = S_PD;
                    cnt_d    = '0;
                    pd_d     = 1'b1;
                    refdiv_d = cap_refdiv_q;
                    fbdiv_d  = cap_fbdiv_q;
                    pdiv1_d  = cap_pdiv1_q;
                    pdiv2_d  = cap_pdiv2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PD: begin
                if (cnt_q == PD_LAST) begin
                    cnt_d = '0;
                    if (byp_q) begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_WAIT_LOCK;
                        pd_d    = 1'b0;
                        stab_d  = '0;
                        tmo_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s_q)
                    stab_inc = (stab_q == STAB_DONE) ? stab_q : stab_q + STAB_W'(1);
                stab_d = stab_inc;
                tmo_d  = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
                // Stability is checked first so a same-cycle timeout loses.
                if (stab_inc == STAB_DONE) begin
                    state_d = S_SW_IN;
                    cnt_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = S_IDLE;
                    pd_d      = 1'b1;
                    err_tmo_d = 1'b1;
                    ready_d   = 1'b1;
                    busy_d    = 1'b0;
                end
            end
            S_SW_IN: begin
                if (cnt_q == SW_LAST) begin
                    state_d  = S_RUN;
                    sel_d    = 1'b1;
                    locked_d = 1'b1;
                    ready_d  = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            cnt_q        <= '0;
            stab_q       <= '0;
            tmo_q        <= '0;
            byp_q        <= 1'b0;
            cap_refdiv_q <= REFDIV_WIDTH'(1);
            cap_fbdiv_q  <= FBDIV_WIDTH'(1);
            cap_pdiv1_q  <= POSTDIV_WIDTH'(1);
            cap_pdiv2_q  <= POSTDIV_WIDTH'(1);
            refdiv_q     <= REFDIV_WIDTH'(1);
            fbdiv_q      <= FBDIV_WIDTH'(1);
            pdiv1_q      <= POSTDIV_WIDTH'(1);
            pdiv2_q      <= POSTDIV_WIDTH'(1);
            pd_q         <= 1'b1;
            sel_q        <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
            err_cfg_q    <= 1'b0;
            err_tmo_q    <= 1'b0;
`ifdef RCU_PLL_LOSS_EN
            lost_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            lock_meta_q  <= lock_meta_d;
            lock_s_q     <= lock_s_d;
            cnt_q        <= cnt_d;
            stab_q       <= stab_d;
            tmo_q        <= tmo_d;
            byp_q        <= byp_d;
            cap_refdiv_q <= cap_refdiv_d;
            cap_fbdiv_q  <= cap_fbdiv_d;
            cap_pdiv1_q  <= cap_pdiv1_d;
            cap_pdiv2_q  <= cap_pdiv2_d;
            refdiv_q     <= refdiv_d;
            fbdiv_q      <= fbdiv_d;
            pdiv1_q      <= pdiv1_d;
            pdiv2_q      <= pdiv2_d;
            pd_q         <= pd_d;
            sel_q        <= sel_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            locked_q     <= locked_d;
            err_cfg_q    <= err_cfg_d;
            err_tmo_q    <= err_tmo_d;
`ifdef RCU_PLL_LOSS_EN
            lost_q       <= lost_d;
`endif
        end
    end

    assign cfg_ready_o  = ready_q;
    assign pll_pd_o     = pd_q;
    assign pll_refdiv_o = refdiv_q;
    assign pll_fbdiv_o  = fbdiv_q;
    assign pll_pdiv1_o  = pdiv1_q;
    assign pll_pdiv2_o  = pdiv2_q;
    assign pll_sel_o    = sel_q;
    assign busy_o       = busy_q;
    assign locked_o     = locked_q;
    assign err_cfg_o    = err_cfg_q;
    assign err_tmo_o    = err_tmo_q;
endmodule

// File: tb/tb_rcu_pll_seq.sv
// tb/tb_rcu_pll_seq.sv - directed bench for rcu_pll_seq with a timeline model and latency pins
module tb_rcu_pll_seq;
    localparam int SWITCH = 4;
    localparam int PDC    = 16;
    localparam int STABLE = 64;
    localparam int TMO    = 4096;
    localparam int M_IDLE = 0, M_SWOUT = 1, M_PD = 2, M_WAIT = 3, M_SWIN = 4, M_RUN = 5;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cfg_valid = 1'b0, cfg_byp = 1'b0, pll_lock = 1'b0;
    logic [5:0]  cfg_refdiv = '0;
    logic [11:0] cfg_fbdiv = '0;
    logic [2:0]  cfg_pdiv1 = '0, cfg_pdiv2 = '0;
    logic        cfg_ready, pll_pd, pll_sel, busy, locked, err_cfg, err_tmo;
    logic [5:0]  pll_refdiv;
    logic [11:0] pll_fbdiv;
    logic [2:0]  pll_pdiv1, pll_pdiv2;

    int vectors = 0, fails = 0, cyc = 0;
    bit chk_en = 1'b0;

    rcu_pll_seq #(.REFDIV_WIDTH(6), .FBDIV_WIDTH(12), .POSTDIV_WIDTH(3), .PD_CYCLES(PDC),
                  .STABLE_CYCLES(STABLE), .LOCK_TIMEOUT(TMO), .SWITCH_CYCLES(SWITCH)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_byp_i(cfg_byp), .cfg_refdiv_i(cfg_refdiv), .cfg_fbdiv_i(cfg_fbdiv),
        .cfg_pdiv1_i(cfg_pdiv1), .cfg_pdiv2_i(cfg_pdiv2), .pll_lock_i(pll_lock),
        .pll_pd_o(pll_pd), .pll_refdiv_o(pll_refdiv), .pll_fbdiv_o(pll_fbdiv),
        .pll_pdiv1_o(pll_pdiv1), .pll_pdiv2_o(pll_pdiv2), .pll_sel_o(pll_sel),
        .busy_o(busy), .locked_o(locked), .err_cfg_o(err_cfg), .err_tmo_o(err_tmo));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Timeline model: phase, time spent in phase, and lock run-length seen through two sync stages.
    int m_mode, m_t, m_run, m_low;
    bit m_l1, m_ls, m_pd, m_sel, m_ready, m_busy, m_locked, m_ecfg, m_etmo, m_cbyp;
    logic [5:0] m_ref, c_ref;
    logic [11:0] m_fb, c_fb;
    logic [2:0] m_p1, m_p2, c_p1, c_p2;

    task automatic model_reset();
        m_mode = M_IDLE; m_t = 0; m_run = 0; m_low = 0; m_l1 = 0; m_ls = 0;
        m_pd = 1; m_sel = 0; m_ready = 1; m_busy = 0; m_locked = 0; m_ecfg = 0; m_etmo = 0;
        m_ref = 1; m_fb = 1; m_p1 = 1; m_p2 = 1;
    endtask

    task automatic enter_wait();
        m_mode = M_WAIT; m_t = 0; m_run = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                m_ecfg = 0;
                case (m_mode)
                    M_IDLE, M_RUN: begin
                        if (cfg_valid && m_ready) begin
                            if (!cfg_byp && (cfg_refdiv == 0 || cfg_fbdiv == 0 || cfg_pdiv1 == 0 || cfg_pdiv2 == 0)) begin
                                m_ecfg = 1;
                            end else begin
                                m_cbyp = cfg_byp; c_ref = cfg_refdiv; c_fb = cfg_fbdiv; c_p1 = cfg_pdiv1; c_p2 = cfg_pdiv2;
                                m_mode = M_SWOUT; m_t = 0; m_sel = 0; m_locked = 0; m_ready = 0; m_busy = 1; m_etmo = 0;
                            end
                        end else if (m_mode == M_RUN) begin
                            m_low = m_ls ? 0 : m_low + 1;
`ifdef RCU_PLL_LOSS_EN
                            if (m_low >= 2) begin
                                enter_wait(); m_sel = 0; m_locked = 0; m_etmo = 1; m_ready = 0; m_busy = 1;
                            end
`endif
                        end
                    end
                    M_SWOUT: begin
                        m_t++;
                        if (m_t == SWITCH) begin
                            m_mode = M_PD; m_t = 0; m_pd = 1;
                            m_ref = c_ref; m_fb = c_fb; m_p1 = c_p1; m_p2 = c_p2;
                        end
                    end
                    M_PD: begin
                        m_t++;
                        if (m_t == PDC) begin
                            if (m_cbyp) begin m_mode = M_IDLE; m_ready = 1; m_busy = 0; end
                            else begin enter_wait(); m_pd = 0; end
                        end
                    end
                    M_WAIT: begin
                        m_run = m_ls ? ((m_run < STABLE) ? m_run + 1 : m_run) : 0;
                        m_t++;
                        if (m_run == STABLE) begin
                            m_mode = M_SWIN; m_t = 0;
                        end else if (m_t == TMO) begin
                            m_mode = M_IDLE; m_pd = 1; m_etmo = 1; m_ready = 1; m_busy = 0;
                        end
                    end
                    M_SWIN: begin
                        m_t++;
                        if (m_t == SWITCH) begin
                            m_mode = M_RUN; m_sel = 1; m_locked = 1; m_ready = 1; m_busy = 0; m_low = 0;
                        end
                    end
                    default: m_mode = M_IDLE;
                endcase
                m_ls = m_l1;
                m_l1 = pll_lock;
            end
        end
    end

    function automatic logic [30:0] dut_vec();
        return {pll_pd, pll_sel, cfg_ready, busy, locked, err_cfg, err_tmo, pll_refdiv, pll_fbdiv, pll_pdiv1, pll_pdiv2};
    endfunction

    function automatic logic [30:0] mdl_vec();
        return {m_pd, m_sel, m_ready, m_busy, m_locked, m_ecfg, m_etmo, m_ref, m_fb, m_p1, m_p2};
    endfunction

    initial forever begin
        @(negedge clk);
        if (rst_n && chk_en) begin
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                fails++;
                $display("FAIL model_compare cyc=%0d got %h expected %h (pd sel rdy busy lck ecfg etmo ref fb p1 p2)",
                         cyc, dut_vec(), mdl_vec());
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit sig(input int which);
        case (which)
            0: return pll_pd;
            1: return pll_sel;
            default: return busy;
        endcase
    endfunction

    task automatic wait_for(input int which, input bit val, input int lim, output int at);
        at = -1;
        for (int n = 0; n < lim; n++) begin
            @(negedge clk);
            if (sig(which) == val) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            vectors++; fails++;
            $display("FAIL wait_sig%0d: level %0d not seen within %0d cycles", which, val, lim);
        end
    endtask

    task automatic send_cfg(input bit byp, input int r, input int f, input int p1, input int p2, output int acc);
        for (int n = 0; n < 50 && !cfg_ready; n++) @(negedge clk);
        cfg_valid = 1; cfg_byp = byp;
        cfg_refdiv = 6'(r); cfg_fbdiv = 12'(f); cfg_pdiv1 = 3'(p1); cfg_pdiv2 = 3'(p2);
        @(negedge clk);
        acc = cyc;
        cfg_valid = 0;
    endtask

    initial begin
        int acc, e, s, n, t, fall;
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, e, s, n, t, fall;
        repeat (3) @(negedge clk);
        check("rst_pd", pll_pd, 1);         check("rst_sel", pll_sel, 0);
        check("rst_ready", cfg_ready, 1);   check("rst_busy", busy, 0);
        check("rst_locked", locked, 0);     check("rst_err_cfg", err_cfg, 0);
        check("rst_err_tmo", err_tmo, 0);   check("rst_refdiv", pll_refdiv, 1);
        check("rst_fbdiv", pll_fbdiv, 1);   check("rst_pdiv1", pll_pdiv1, 1);
        check("rst_pdiv2", pll_pdiv2, 1);
        #1 rst_n = 1; chk_en = 1;
        @(negedge clk);

        send_cfg(0, 1, 0, 2, 1, acc);
        check("badcfg_err_pulse", err_cfg, 1); check("badcfg_ready", cfg_ready, 1); check("badcfg_busy", busy, 0);
        @(negedge clk);
        check("badcfg_err_single", err_cfg, 0); check("badcfg_fbdiv", pll_fbdiv, 1);

        send_cfg(0, 1, 40, 2, 1, acc);
        wait_for(0, 1, 50, e);
        wait_for(0, 0, 50, e);
        check("pd_fall_latency", e - acc, SWITCH + PDC);
        repeat (49) @(negedge clk);
        pll_lock = 1;
        wait_for(1, 1, 300, s);
        check("sel_rise_latency", s - acc, 139);
        check("run_locked", locked, 1); check("run_fbdiv", pll_fbdiv, 40); check("run_pdiv1", pll_pdiv1, 2);

        pll_lock = 0;
`ifdef RCU_PLL_LOSS_EN
        fall = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 3) pll_lock = 1;
            if (!pll_sel) begin fall = i; break; end
        end
        check("loss_sel_fall", fall, 4); check("loss_err_tmo", err_tmo, 1); check("loss_locked", locked, 0);
        wait_for(1, 1, 200, s);
        check("loss_relocked", locked, 1);
`else
        repeat (3) @(negedge clk);
        pll_lock = 1;
        repeat (5) @(negedge clk);
        check("noloss_locked", locked, 1); check("noloss_sel", pll_sel, 1);
`endif

        pll_lock = 0;
        send_cfg(0, 2, 50, 1, 1, acc);
        wait_for(0, 1, 50, e);
        wait_for(0, 0, 50, e);
        repeat (10) @(negedge clk);
        pll_lock = 1;
        repeat (63) @(negedge clk);
        pll_lock = 0;
        @(negedge clk);
        pll_lock = 1;
        n = cyc;
        wait_for(1, 1, 200, s);
        check("relock_sel_latency", s - n, 70); check("relock_refdiv", pll_refdiv, 2);

        pll_lock = 0;
        send_cfg(0, 1, 40, 2, 1, acc);
        wait_for(0, 1, 50, e);
        wait_for(0, 0, 50, e);
        wait_for(0, 1, 5000, t);
        check("timeout_len", t - e, TMO); check("tmo_err", err_tmo, 1);
        check("tmo_busy", busy, 0); check("tmo_ready", cfg_ready, 1); check("tmo_sel", pll_sel, 0);

        send_cfg(1, 3, 7, 2, 2, acc);
        check("byp_err_tmo_clear", err_tmo, 0); check("byp_busy", busy, 1);
        wait_for(2, 0, 100, s);
        check("byp_done_latency", s - acc, SWITCH + PDC);
        check("byp_pd", pll_pd, 1); check("byp_refdiv", pll_refdiv, 3); check("byp_fbdiv", pll_fbdiv, 7);

        send_cfg(0, 1, 40, 2, 1, acc);
        wait_for(0, 0, 50, e);
        repeat (5) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("async_rst_pd", pll_pd, 1); check("async_rst_sel", pll_sel, 0);
        check("async_rst_busy", busy, 0); check("async_rst_ready", cfg_ready, 1);
        check("async_rst_fbdiv", pll_fbdiv, 1);
        @(negedge clk);
        #1 rst_n = 1;
        repeat (3) @(negedge clk);
        check("post_rst_pd", pll_pd, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
